// File: rtl/apb_mem_slave_pkg.sv
// Shared types and width helpers for the APB memory slave.
//   apb_state_t  : transfer FSM states.
//   APB_WAIT_W   : width of the wait-state counter (supports 0..15 waits).
//   strb_width() : byte lanes per data word.
//   lsb_width()  : number of byte-offset bits below the word index.
//   idx_width()  : bits needed to index a memory of the given depth.
package apb_mem_slave_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } apb_state_t;

  localparam int unsigned APB_WAIT_W = 4;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned lsb_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_slave_sp_ram_be.sv
// Single-port RAM with per-byte write enables.
//   clk      : write clock.
//   i_addr   : word address shared by read and write.
//   i_be     : byte-lane write enables; any set lane is written on the rising edge.
//   i_wdata  : write data.
//   o_rdata  : combinational read of the addressed word.
// Contents are deliberately not reset.
module sp_ram_be
  import apb_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                                   clk,
  input  logic [idx_width(DEPTH)-1:0]            i_addr,
  input  logic [strb_width(DATA_WIDTH)-1:0]      i_be,
  input  logic [DATA_WIDTH-1:0]                  i_wdata,
  output logic [DATA_WIDTH-1:0]                  o_rdata
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 slave wrapping a byte-enabled single-port memory.
//   clk, rst_n   : clock and asynchronous active-low reset.
//   i_paddr      : byte address, decoded into word index + alignment check.
//   i_psel       : slave select; dropping it during ACCESS aborts the transfer.
//   i_penable    : access-phase indicator.
//   i_pwrite     : 1 = write, 0 = read.
//   i_pwdata     : write data, taken at the completion edge.
//   i_pstrb      : byte strobes, taken at the completion edge.
//   o_prdata     : registered read data (0 for writes and errored reads).
//   o_pready     : registered transfer-complete, after RD_WAIT/WR_WAIT wait cycles.
//   o_pslverr    : registered error for misaligned or out-of-range accesses.
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  i_paddr,
  input  logic                                   i_psel,
  input  logic                                   i_penable,
  input  logic                                   i_pwrite,
  input  logic [DATA_WIDTH-1:0]                  i_pwdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]      i_pstrb,
  output logic [DATA_WIDTH-1:0]                  o_prdata,
  output logic                                   o_pready,
  output logic                                   o_pslverr
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned LSB    = lsb_width(DATA_WIDTH);
  localparam int unsigned IDX_W  = idx_width(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [APB_WAIT_W-1:0] RD_W        = APB_WAIT_W'(RD_WAIT);
  localparam logic [APB_WAIT_W-1:0] WR_W        = APB_WAIT_W'(WR_WAIT);

  // State
  apb_state_t            r_state, w_state_d;
  logic [APB_WAIT_W-1:0] r_cnt,   w_cnt_d;
  logic                  r_write, w_write_d;
  logic [IDX_W-1:0]      r_index, w_index_d;
  logic                  r_err,   w_err_d;
  logic                  r_pready,  w_pready_d;
  logic                  r_pslverr, w_pslverr_d;
  logic [DATA_WIDTH-1:0] r_prdata,  w_prdata_d;

  // Address decode of the live bus (only meaningful at the setup edge)
  logic [ADDR_WIDTH-1:0] w_index_full;
  logic [IDX_W-1:0]      w_index;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_addr_err;
  logic [APB_WAIT_W-1:0] w_wait;

  assign w_index_full = i_paddr >> LSB;
  assign w_index      = w_index_full[IDX_W-1:0];
  assign w_misalign   = |(i_paddr & OFFSET_MASK);
  assign w_range_err  = 64'(w_index_full) >= 64'(DEPTH);
  assign w_addr_err   = w_misalign | w_range_err;
  assign w_wait       = i_pwrite ? WR_W : RD_W;

  // RAM interface: the port follows the live address in IDLE so a zero-wait read
  // can capture data at the setup edge; in ACCESS it stays on the latched index.
  logic [IDX_W-1:0]      w_ram_addr;
  logic [STRB_W-1:0]     w_ram_be;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_ram_addr = (r_state == StIdle) ? w_index : r_index;

  sp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (i_pwdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_write_d   = r_write;
    w_index_d   = r_index;
    w_err_d     = r_err;
    w_pready_d  = r_pready;
    w_pslverr_d = r_pslverr;
    w_prdata_d  = r_prdata;
    w_ram_be    = '0;

    unique case (r_state)
      StIdle: begin
        if (i_psel && !i_penable) begin
          w_state_d = StAccess;
          w_write_d = i_pwrite;
          w_index_d = w_index;
          w_err_d   = w_addr_err;
          w_cnt_d   = w_wait;
          if (w_wait == '0) begin
            w_pready_d  = 1'b1;
            w_pslverr_d = w_addr_err;
            w_prdata_d  = (!i_pwrite && !w_addr_err) ? w_ram_rdata : '0;
          end
        end
      end

      StAccess: begin
        if (!i_psel) begin
          // Abort: master gave up; nothing is committed.
          w_state_d   = StIdle;
          w_cnt_d     = '0;
          w_pready_d  = 1'b0;
          w_pslverr_d = 1'b0;
          w_prdata_d  = '0;
        end else if (r_pready) begin
          if (i_penable) begin
            if (r_write && !r_err) begin
              w_ram_be = i_pstrb;
            end
            w_state_d   = StIdle;
            w_pready_d  = 1'b0;
            w_pslverr_d = 1'b0;
            w_prdata_d  = '0;
          end
        end else if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
          if (r_cnt == APB_WAIT_W'(1)) begin
            w_pready_d  = 1'b1;
            w_pslverr_d = r_err;
            w_prdata_d  = (!r_write && !r_err) ? w_ram_rdata : '0;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_index   <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_write   <= w_write_d;
      r_index   <= w_index_d;
      r_err     <= w_err_d;
      r_pready  <= w_pready_d;
      r_pslverr <= w_pslverr_d;
      r_prdata  <= w_prdata_d;
    end
  end

  assign o_prdata  = r_prdata;
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave. Two instances share one APB bus with
// separate selects: A (13-bit address, 1024 words, RD_WAIT=1, WR_WAIT=0) and
// B (12-bit address, 1000 words, RD_WAIT=3, WR_WAIT=2).
module tb_apb_mem_slave;

  localparam int DEPTH_A = 1024;
  localparam int DEPTH_B = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] bus_addr = '0;
  logic        bus_penable = 1'b0;
  logic        bus_pwrite = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_strb = '0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  always #5 clk = ~clk;

  apb_mem_slave #(
    .DATA_WIDTH (32), .ADDR_WIDTH (13), .DEPTH (DEPTH_A), .RD_WAIT (1), .WR_WAIT (0)
  ) u_dut_a (
    .clk (clk), .rst_n (rst_n), .i_paddr (bus_addr), .i_psel (psel_a),
    .i_penable (bus_penable), .i_pwrite (bus_pwrite), .i_pwdata (bus_wdata),
    .i_pstrb (bus_strb), .o_prdata (prdata_a), .o_pready (pready_a), .o_pslverr (pslverr_a)
  );

  apb_mem_slave #(
    .DATA_WIDTH (32), .ADDR_WIDTH (12), .DEPTH (DEPTH_B), .RD_WAIT (3), .WR_WAIT (2)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .i_paddr (bus_addr[11:0]), .i_psel (psel_b),
    .i_penable (bus_penable), .i_pwrite (bus_pwrite), .i_pwdata (bus_wdata),
    .i_pstrb (bus_strb), .o_prdata (prdata_b), .o_pready (pready_b), .o_pslverr (pslverr_b)
  );

  typedef struct {
    int          dut;
    int          waits;
    logic [31:0] rdata;
    bit          err;
    bit          is_read;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] mdl [2][1024];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic bit addr_err(input int d, input logic [12:0] a);
    int ai;
    ai = int'(a);
    return ((ai % 4) != 0) || ((ai / 4) >= depth_of(d));
  endfunction

  function automatic int pool_idx(input int d, input int k);
    return (k < 8) ? k : depth_of(d) - 10 + k;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, req);
    end
  endtask

  // Monitor: pops an expectation whenever a DUT raises pready.
  initial begin : monitor
    int          wcnt [2];
    logic        rdy, sel, en, slv;
    logic [31:0] rd;
    exp_t        e;
    wcnt[0] = 0;
    wcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rdy = (d == 0) ? pready_a  : pready_b;
        slv = (d == 0) ? pslverr_a : pslverr_b;
        rd  = (d == 0) ? prdata_a  : prdata_b;
        sel = (d == 0) ? psel_a    : psel_b;
        en  = bus_penable;
        if (rdy) begin
          n_vec++;
          if (exp_q.size() == 0 || exp_q[0].dut != d) begin
            n_err++;
            $display("FAIL unexpected_pready dut%0d: got pready=1, required 0", d);
          end else begin
            e = exp_q.pop_front();
            if (wcnt[d] != e.waits || slv !== e.err || (e.is_read && rd !== e.rdata)) begin
              n_err++;
              $display("FAIL xfer dut%0d: got waits=%0d err=%0b rdata=0x%08h, required waits=%0d err=%0b rdata=0x%08h (read=%0b)",
                       d, wcnt[d], slv, rd, e.waits, e.err, e.rdata, e.is_read);
            end
          end
          wcnt[d] = 0;
        end else if (!rst_n || !sel) begin
          wcnt[d] = 0;
        end else if (en) begin
          wcnt[d]++;
        end
      end
    end
  end

  task automatic set_sel(input int d, input logic v);
    if (d == 0) psel_a = v; else psel_b = v;
  endtask

  // Starts at posedge+1; returns at posedge+1 after completion (or abort).
  // abort_at >= 0 drops psel after that many access-phase edges.
  task automatic xfer(input int d, input logic [12:0] a, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input int abort_at);
    exp_t e;
    bit   er;
    int   t;
    logic rdy;
    er = addr_err(d, a);
    if (abort_at < 0) begin
      e.dut     = d;
      e.waits   = wr ? ((d == 0) ? 0 : 2) : ((d == 0) ? 1 : 3);
      e.err     = er;
      e.is_read = !wr;
      e.rdata   = (!wr && !er) ? mdl[d][int'(a) / 4] : 32'h0;
      exp_q.push_back(e);
      if (wr && !er) mdl[d][int'(a) / 4] = merge(mdl[d][int'(a) / 4], wd, st);
    end
    bus_addr    = a;
    bus_pwrite  = wr;
    bus_wdata   = wd;
    bus_strb    = st;
    bus_penable = 1'b0;
    set_sel(d, 1'b1);
    set_sel(1 - d, 1'b0);
    @(posedge clk);
    #1;
    bus_penable = 1'b1;
    // Address and direction must be ignored once the setup edge has passed.
    bus_addr    = 13'($urandom);
    bus_pwrite  = ~wr;
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      set_sel(d, 1'b0);
      bus_penable = 1'b0;
      repeat (2) @(negedge clk);
      rdy = (d == 0) ? pready_a : pready_b;
      check("abort_no_pready", {31'h0, rdy}, 32'h0);
      @(posedge clk);
      #1;
    end else begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
        rdy = (d == 0) ? pready_a : pready_b;
      end while (!rdy && t < 40);
      if (!rdy) begin
        n_vec++;
        n_err++;
        $display("FAIL pready_timeout dut%0d: got no pready in %0d cycles, required pready", d, t);
      end
      @(posedge clk);
      #1;
      set_sel(d, 1'b0);
      bus_penable = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          t0;
    int          d, k, r, idx, ab;
    bit          wr;
    logic [12:0] a;

    repeat (2) @(posedge clk);
    #1;
    check("reset_pready_a",  {31'h0, pready_a},  32'h0);
    check("reset_pslverr_a", {31'h0, pslverr_a}, 32'h0);
    check("reset_prdata_a",  prdata_a,           32'h0);
    check("reset_pready_b",  {31'h0, pready_b},  32'h0);
    check("reset_prdata_b",  prdata_b,           32'h0);
    rst_n = 1'b1;
    idle(1);

    // penable without setup in IDLE must be ignored
    psel_a      = 1'b1;
    bus_penable = 1'b1;
    idle(2);
    check("no_setup_ignored", {31'h0, pready_a}, 32'h0);
    psel_a      = 1'b0;
    bus_penable = 1'b0;
    idle(1);

    for (int dd = 0; dd < 2; dd++)
      for (int kk = 0; kk < 10; kk++)
        xfer(dd, 13'(pool_idx(dd, kk) * 4), 1'b1, $urandom, 4'hF, -1);

    // Directed: zero-wait write, one-wait read, byte strobes, errors on A
    xfer(0, 13'h010, 1'b1, 32'hDEADBEEF, 4'hF, -1);
    xfer(0, 13'h010, 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h010, 1'b1, 32'h11223344, 4'hF, -1);
    xfer(0, 13'h010, 1'b1, 32'hAABBCCDD, 4'b0101, -1);
    xfer(0, 13'h010, 1'b0, 32'h0, 4'h0, -1);
    check("strobe_model", mdl[0][4], 32'h11BB33DD);
    xfer(0, 13'h011, 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h1000, 1'b1, 32'h5A5A5A5A, 4'hF, -1);
    xfer(0, 13'(4 * 1023), 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h000, 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h014, 1'b1, 32'hFFFFFFFF, 4'h0, -1);
    xfer(0, 13'h014, 1'b0, 32'h0, 4'h0, -1);

    // Directed on B: back-to-back reads, range boundary, abort
    t0 = cyc;
    xfer(1, 13'h004, 1'b0, 32'h0, 4'h0, -1);
    xfer(1, 13'h008, 1'b0, 32'h0, 4'h0, -1);
    xfer(1, 13'h00C, 1'b0, 32'h0, 4'h0, -1);
    check("b2b_3_reads_cycles", 32'(cyc - t0), 32'd15);
    xfer(1, 13'(4 * 1000), 1'b1, 32'h12345678, 4'hF, -1);
    xfer(1, 13'(4 * 999), 1'b0, 32'h0, 4'h0, -1);
    xfer(1, 13'h00C, 1'b1, 32'hCAFEF00D, 4'hF, 1);
    xfer(1, 13'h00C, 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h008, 1'b0, 32'h0, 4'h0, 0);
    xfer(0, 13'h008, 1'b0, 32'h0, 4'h0, -1);

    // Reset mid-read on A while pready is high
    bus_addr    = 13'h014;
    bus_pwrite  = 1'b0;
    bus_penable = 1'b0;
    psel_a      = 1'b1;
    @(posedge clk);
    #1;
    bus_penable = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_pready", {31'h0, pready_a}, 32'h1);
    check("pre_reset_prdata", prdata_a, mdl[0][5]);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_pready",  {31'h0, pready_a},  32'h0);
    check("async_reset_pslverr", {31'h0, pslverr_a}, 32'h0);
    check("async_reset_prdata",  prdata_a,           32'h0);
    psel_a      = 1'b0;
    bus_penable = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(1);
    xfer(0, 13'h014, 1'b0, 32'h0, 4'h0, -1);
    xfer(0, 13'h010, 1'b0, 32'h0, 4'h0, -1);

    // Randomised traffic over the pool words plus error and abort cases
    for (int n = 0; n < 120; n++) begin
      d   = int'($urandom_range(0, 1));
      k   = int'($urandom_range(0, 9));
      r   = int'($urandom_range(0, 9));
      wr  = 1'($urandom_range(0, 1));
      idx = pool_idx(d, k);
      a   = 13'(idx * 4);
      ab  = -1;
      if (r == 0) a = a | 13'($urandom_range(1, 3));
      if (r == 1) a = 13'(((d == 0) ? int'($urandom_range(1024, 2047))
                                    : int'($urandom_range(1000, 1023))) * 4);
      if (r == 2) begin
        if (d == 1) ab = wr ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
        else if (!wr) ab = 0;
      end
      xfer(d, a, wr, $urandom, 4'($urandom), ab);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB4-compliant slave wrapping a parametrised single-port memory for the accelerator's weight/activation store.
- Adds over the previous APB memory block: pready with configurable wait states, pstrb byte-lane writes, pslverr on out-of-range or misaligned access, and protocol-abort handling.
- Sits behind the APB interconnect; one instance per memory region.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, byte-address width of paddr.
- DEPTH, 1024, number of DATA_WIDTH words implemented; must be ≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RD_WAIT, 1, wait cycles inserted before pready on reads (0..15).
- WR_WAIT, 0, wait cycles inserted before pready on writes (0..15).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- paddr, in, ADDR_WIDTH, byte address.
- psel, in, 1, slave select.
- penable, in, 1, access-phase indicator.
- pwrite, in, 1, 1 = write, 0 = read.
- pwdata, in, DATA_WIDTH, write data.
- pstrb, in, DATA_WIDTH/8, write byte strobes.
- prdata, out, DATA_WIDTH, read data; valid only while pready=1 on a read.
- pready, out, 1, transfer-complete.
- pslverr, out, 1, error response; valid only while pready=1.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0.
  - Memory contents are not cleared.
- All outputs are registered.
- Address decode:
  - word index = paddr[ADDR_WIDTH-1:LSB], where LSB = log2(DATA_WIDTH/8).
  - err = (paddr[LSB-1:0] != 0) or (index ≥ DEPTH).
- States: IDLE, ACCESS.
- Setup edge: psel=1 and penable=0 sampled in IDLE.
  - Latch pwrite, index, err.
  - Load counter with W = (pwrite ? WR_WAIT : RD_WAIT).
  - Go to ACCESS.
  - If W=0, also set pready=1 and pslverr=err on this edge. For an error-free read, prdata=mem[index]; for an error read, prdata=0.
- In ACCESS, while counter>0: decrement each edge.
  - When counter transitions 1→0, set pready=1, pslverr=err, and prdata as above.
- Access-phase length is exactly W+1 cycles. pready stays low for the first W cycles and is high in the last.
- Completion edge: ACCESS with pready=1, psel=1, penable=1.
  - Write with err=0: for each byte lane b where pstrb[b]=1, mem[index][8b+7:8b] <= pwdata lane b. Unstrobed lanes are unchanged.
  - Write with err=1, or pstrb=0: memory is unchanged.
  - Then pready=0, pslverr=0, prdata=0, state=IDLE.
- Reads ignore pstrb and pwdata.
- Back-to-back transfers: a new setup may be sampled on the cycle after completion. Minimum per-transfer time is 2+W cycles.
- Abort: psel=0 sampled while in ACCESS.
  - Go to IDLE, clear pready/pslverr/prdata.
  - No memory write occurs.
- In IDLE, penable=1 without a prior setup is ignored.
- paddr, pwrite, pwdata and pstrb are re-sampled only at setup. Changes during ACCESS are ignored, except that pwdata and pstrb are used at the completion edge per the APB4 hold requirement.
- Reset asserted mid-transfer: immediate return to reset values; an in-flight write is not committed.

Decomposition:
- data_types_pkg additions:
  - apb_state_t enum {IDLE, ACCESS}.
  - localparam function clog2-based STRB_WIDTH/LSB helpers.
  - APB_WAIT_W=4.
- One sub-module, sp_ram_be:
  - Parameterised DATA_WIDTH/DEPTH single-port RAM.
  - Per-byte write enables, synchronous write.
  - Combinational (or registered, per read-path choice) read.
- The FSM, decode and wait counter live in apb_mem_slave.

Test Plan:
- WR_WAIT=0, RD_WAIT=1: write 0xDEADBEEF to 0x010 with pstrb=0xF, then read 0x010 → write pready in the first access cycle; read pready in the second access cycle with prdata=0xDEADBEEF, pslverr=0.
- Byte strobes: mem[4]=0x11223344, write 0xAABBCCDD to 0x010 with pstrb=0b0101 → read returns 0x11BB33DD.
- Errors:
  - Read from paddr=0x011 → pready with pslverr=1, prdata=0.
  - Write to index DEPTH (paddr=0x1000 when ADDR_WIDTH=13) → pslverr=1, and no other word changes.
- RD_WAIT=3: read → pready is low for 3 access cycles and high on the 4th; three back-to-back reads complete in 3×5 cycles.
- Abort: drop psel during write wait (WR_WAIT=2) → no pready; target word keeps its old value; the next transfer completes normally.
- Reset: pulse rst_n low during a read access → pready/pslverr/prdata=0 asynchronously; memory is retained, and a subsequent read returns the pre-reset data.
